// File: rtl/trace_serializer_pkg.sv
// Shared widths, word type and FSM state encoding for the trace serializer.
// Exponent clamp helper used when a new word is loaded.
package trace_serializer_pkg;

  localparam int TRB_WIDTH       = 32;
  localparam int TRB_MAX_TRACES  = 8;
  localparam int TRB_MAX_EXP     = $clog2(TRB_MAX_TRACES);
  localparam int TRB_NTRACE_BITS = TRB_MAX_EXP + 1;
  localparam int TRB_CNT_W       = $clog2(TRB_WIDTH) + 1;

  typedef logic [TRB_WIDTH-1:0] trb_word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHIFT = 1'b1
  } trb_state_t;

  function automatic logic [TRB_NTRACE_BITS-1:0] clamp_exp(input logic [TRB_NTRACE_BITS-1:0] e);
    if (e > TRB_NTRACE_BITS'(TRB_MAX_EXP)) begin
      return TRB_NTRACE_BITS'(TRB_MAX_EXP);
    end
    return e;
  endfunction

endpackage

// File: rtl/trace_serializer_if.sv
// Buffer-read and trace-stream signals of the serializer.
// Stream handshake: a beat transfers on a rising edge where TRACE_VALID_O and TRACE_READY_I are both 1.
interface trace_serializer_if;
  import trace_serializer_pkg::*;

  logic [TRB_NTRACE_BITS-1:0] EXP_TRACES_I;
  logic                       LOAD_PERM_I;
  trb_word_t                  DATA_I;
  logic                       LOAD_O;
  logic                       TRACE_VALID_O;
  logic                       TRACE_READY_I;
  logic [TRB_MAX_TRACES-1:0]  TRACE_O;
  trb_state_t                 dbg_state;

  modport slave (
    input  EXP_TRACES_I, LOAD_PERM_I, DATA_I, TRACE_READY_I,
    output LOAD_O, TRACE_VALID_O, TRACE_O, dbg_state
  );

  modport master (
    output EXP_TRACES_I, LOAD_PERM_I, DATA_I, TRACE_READY_I,
    input  LOAD_O, TRACE_VALID_O, TRACE_O, dbg_state
  );
endinterface

// File: rtl/trace_serializer.sv
// Splits buffer words into 2**exp-bit beats on a valid/ready trace stream.
// Optional TRACE_SERIALIZER_STALL_CNT_EN adds a saturating 16-bit stall counter output.
module trace_serializer
  import trace_serializer_pkg::*;
(
  input  logic                CLK_I,
  input  logic                RST_NI,
`ifdef TRACE_SERIALIZER_STALL_CNT_EN
  output logic [15:0]         STALL_CNT_O,
`endif
  trace_serializer_if.slave   bus
);

  localparam int WIDTH = TRB_WIDTH;
  localparam int MT    = TRB_MAX_TRACES;
  localparam int NB    = TRB_NTRACE_BITS;
  localparam int CW    = TRB_CNT_W;

  trb_state_t          state_q, state_d;
  trb_word_t           shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d, last_cnt;
  logic [NB-1:0]       exp_q, exp_d;
  logic                valid, last_beat, handshake, free, load;
  logic [CW+TRB_MAX_EXP-1:0] bit_off;
  trb_word_t           window;
  logic [MT-1:0]       lanes;

  always_comb begin
    valid     = (state_q == ST_SHIFT);
    last_cnt  = CW'(WIDTH >> exp_q) - CW'(1);
    last_beat = (cnt_q == last_cnt);
    handshake = valid & bus.TRACE_READY_I;
    free      = (state_q == ST_EMPTY) | (handshake & last_beat);
    // Gated by reset so the buffer never sees a consume while the block is held.
    load      = free & bus.LOAD_PERM_I & RST_NI;

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    if (load) begin
      state_d = ST_SHIFT;
      shift_d = bus.DATA_I;
      exp_d   = clamp_exp(bus.EXP_TRACES_I);
      cnt_d   = '0;
    end else if (free) begin
      state_d = ST_EMPTY;
    end else if (handshake) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Lane mux: beat n of width T starts at bit n*T of the latched word.
  always_comb begin
    bit_off = (CW+TRB_MAX_EXP)'(cnt_q) << exp_q;
    window  = shift_q >> bit_off;
    lanes   = '0;
    for (int k = 0; k < MT; k++) begin
      lanes[k] = (valid && ((k >> exp_q) == 0)) ? window[k] : 1'b0;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= ST_EMPTY;
      shift_q <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.LOAD_O        = load;
  assign bus.TRACE_VALID_O = valid;
  assign bus.TRACE_O       = lanes;
  assign bus.dbg_state     = state_q;

`ifdef TRACE_SERIALIZER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      stall_q <= '0;
    end else if (valid && !bus.TRACE_READY_I && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign STALL_CNT_O = stall_q;
`endif

endmodule

// File: tb/tb_trace_serializer.sv
// Self-checking bench for trace_serializer: beat scoreboard, stalls, exponent changes, reset and word round trip.
// Inputs change at the falling edge; outputs are sampled 1ns later.
module tb_trace_serializer;
  import trace_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_serializer_if bus();
`ifdef TRACE_SERIALIZER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  trace_serializer dut (
    .CLK_I       (clk),
    .RST_NI      (rst_n),
`ifdef TRACE_SERIALIZER_STALL_CNT_EN
    .STALL_CNT_O (stall_cnt),
`endif
    .bus         (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  sb_q[$];
  logic [31:0] word_q[$];

  logic       o_load, o_valid;
  logic [7:0] o_trace;

  assert property (@(posedge clk) disable iff (!rst_n) !bus.LOAD_PERM_I |-> !bus.LOAD_O)
    else $error("FAIL load_without_perm");

  task automatic cycle(input logic perm, input logic [31:0] data, input logic [3:0] e, input logic rdy);
    @(negedge clk);
    bus.LOAD_PERM_I   = perm;
    bus.DATA_I        = data;
    bus.EXP_TRACES_I  = e;
    bus.TRACE_READY_I = rdy;
    #1;
    o_load  = bus.LOAD_O;
    o_valid = bus.TRACE_VALID_O;
    o_trace = bus.TRACE_O;
  endtask

  task automatic push_word(input logic [31:0] word, input logic [3:0] e);
    int t, n, ce;
    logic [7:0] b;
    ce = (e > 3) ? 3 : int'(e);
    t = 1 << ce;
    n = 32 / t;
    for (int i = 0; i < n; i++) begin
      b = 8'h00;
      for (int k = 0; k < t; k++) b[k] = word[i*t + k];
      sb_q.push_back(b);
    end
  endtask

  task automatic test_reset();
    bus.LOAD_PERM_I = 1'b1;
    bus.DATA_I = 32'hFFFF_FFFF;
    bus.EXP_TRACES_I = 4'd0;
    bus.TRACE_READY_I = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.LOAD_O !== 1'b0) begin n_err++; $display("FAIL reset_load got=%b exp=0", bus.LOAD_O); end
    n_cmp++; if (bus.TRACE_VALID_O !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.TRACE_VALID_O); end
    n_cmp++; if (bus.TRACE_O !== 8'h00) begin n_err++; $display("FAIL reset_trace got=%h exp=00", bus.TRACE_O); end
    n_cmp++; if (bus.dbg_state !== ST_EMPTY) begin n_err++; $display("FAIL reset_state got=%0d exp=0", bus.dbg_state); end
    @(negedge clk);
    bus.LOAD_PERM_I = 1'b0;
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 4'd0, 1'b1);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got=%b exp=0", o_valid); end
  endtask

  task automatic test_exp0();
    logic [31:0] w;
    logic [7:0]  e_b;
    int beats, loads;
    w = 32'hA5A5_0F0F; beats = 0; loads = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(i == 0, w, 4'd0, 1'b1);
      if (o_valid) begin
        e_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
        n_cmp++; if (o_trace !== e_b) begin n_err++; $display("FAIL exp0_beat%0d got=%h exp=%h", beats, o_trace, e_b); end
        beats++;
      end
      if (o_load) begin loads++; push_word(w, 4'd0); end
    end
    n_cmp++; if (beats != 32) begin n_err++; $display("FAIL exp0_beat_count got=%0d exp=32", beats); end
    n_cmp++; if (loads != 1) begin n_err++; $display("FAIL exp0_load_count got=%0d exp=1", loads); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[2];
    logic [7:0]  e_b;
    int loaded, beats, first, last;
    w[0] = 32'h1234_5678; w[1] = 32'hDEAD_BEEF;
    loaded = 0; beats = 0; first = -1; last = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(loaded < 2, (loaded < 2) ? w[loaded] : 32'h0, 4'd3, 1'b1);
      if (o_load && loaded == 1) begin
        n_cmp++; if (!(o_valid && beats == 3)) begin n_err++; $display("FAIL b2b_second_load_at beat=%0d valid=%b exp beat=3 valid=1", beats, o_valid); end
      end
      if (o_valid) begin
        e_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
        n_cmp++; if (o_trace !== e_b) begin n_err++; $display("FAIL b2b_beat%0d got=%h exp=%h", beats, o_trace, e_b); end
        if (first < 0) first = i;
        last = i;
        beats++;
      end
      if (o_load) begin push_word(w[loaded], 4'd3); loaded++; end
    end
    n_cmp++; if (beats != 8) begin n_err++; $display("FAIL b2b_beat_count got=%0d exp=8", beats); end
    n_cmp++; if (last - first != 7) begin n_err++; $display("FAIL b2b_span got=%0d exp=7", last - first); end
  endtask

  task automatic test_stall();
    logic [31:0] w[2];
    logic [7:0]  e_b, p_trace;
    logic rdy, p_valid, p_rdy;
    int loaded, beats, stalls;
`ifdef TRACE_SERIALIZER_STALL_CNT_EN
    logic [15:0] s0;
    s0 = stall_cnt;
`endif
    w[0] = $urandom; w[1] = $urandom;
    loaded = 0; beats = 0; stalls = 0; p_valid = 0; p_rdy = 1; p_trace = 0;
    for (int i = 0; i < 60; i++) begin
      rdy = (i % 3) == 0;
      cycle(loaded < 2, (loaded < 2) ? w[loaded] : 32'h0, 4'd2, rdy);
      if (p_valid && !p_rdy) begin
        n_cmp++; if (!o_valid || o_trace !== p_trace) begin n_err++; $display("FAIL stall_hold valid=%b got=%h exp=%h", o_valid, o_trace, p_trace); end
      end
      if (o_valid && !rdy) stalls++;
      if (o_valid && rdy) begin
        e_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
        n_cmp++; if (o_trace !== e_b) begin n_err++; $display("FAIL stall_beat%0d got=%h exp=%h", beats, o_trace, e_b); end
        beats++;
      end
      if (o_load) begin push_word(w[loaded], 4'd2); loaded++; end
      p_valid = o_valid; p_rdy = rdy; p_trace = o_trace;
    end
    n_cmp++; if (beats != 16) begin n_err++; $display("FAIL stall_beat_count got=%0d exp=16", beats); end
`ifdef TRACE_SERIALIZER_STALL_CNT_EN
    n_cmp++; if (stall_cnt - s0 !== 16'(stalls)) begin n_err++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt - s0, stalls); end
`endif
  endtask

  task automatic test_no_perm();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, $urandom, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      n_cmp++; if (o_load !== 1'b0 || o_valid !== 1'b0) begin n_err++; $display("FAIL no_perm cyc%0d load=%b valid=%b exp 0/0", i, o_load, o_valid); end
    end
  endtask

  task automatic test_exp_change();
    logic [31:0] w[2];
    logic [7:0]  e_b;
    logic [3:0]  e;
    int loaded, beats;
    w[0] = $urandom; w[1] = $urandom;
    loaded = 0; beats = 0;
    for (int i = 0; i < 40; i++) begin
      e = (beats >= 2) ? 4'd3 : 4'd1;
      cycle(loaded < 2, (loaded < 2) ? w[loaded] : 32'h0, e, 1'b1);
      if (o_valid) begin
        e_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
        n_cmp++; if (o_trace !== e_b) begin n_err++; $display("FAIL expchg_beat%0d got=%h exp=%h", beats, o_trace, e_b); end
        beats++;
      end
      if (o_load) begin push_word(w[loaded], e); loaded++; end
    end
    n_cmp++; if (beats != 20) begin n_err++; $display("FAIL expchg_beat_count got=%0d exp=20", beats); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    logic [7:0]  e_b;
    int beats, loads;
    w = $urandom; beats = 0;
    for (int i = 0; i < 40 && beats < 5; i++) begin
      cycle(i == 0, w, 4'd0, 1'b1);
      if (o_valid) begin void'(sb_q.pop_front()); beats++; end
      if (o_load) push_word(w, 4'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.TRACE_VALID_O !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b exp=0", bus.TRACE_VALID_O); end
    n_cmp++; if (bus.TRACE_O !== 8'h00) begin n_err++; $display("FAIL midrst_trace got=%h exp=00", bus.TRACE_O); end
    sb_q.delete();
    @(negedge clk);
    bus.LOAD_PERM_I = 1'b0;
    rst_n = 1'b1;
    cycle(1'b0, 32'h0, 4'd0, 1'b1);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale valid=%b exp=0", o_valid); end
    w = $urandom; beats = 0; loads = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(i == 0, w, 4'd0, 1'b1);
      if (o_valid) begin
        e_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
        n_cmp++; if (o_trace !== e_b) begin n_err++; $display("FAIL midrst_beat%0d got=%h exp=%h", beats, o_trace, e_b); end
        beats++;
      end
      if (o_load) begin loads++; push_word(w, 4'd0); end
    end
    n_cmp++; if (beats != 32 || loads != 1) begin n_err++; $display("FAIL midrst_counts beats=%0d loads=%0d exp 32/1", beats, loads); end
  endtask

  task automatic test_round_trip();
    logic [3:0]  e_list[5];
    logic [31:0] w[3];
    logic [31:0] acc, e_w;
    int ce, t, n, nb, loaded, got;
    e_list[0] = 4'd0; e_list[1] = 4'd1; e_list[2] = 4'd2; e_list[3] = 4'd3; e_list[4] = 4'd7;
    for (int j = 0; j < 5; j++) begin
      ce = (e_list[j] > 3) ? 3 : int'(e_list[j]);
      t = 1 << ce; n = 32 / t;
      for (int m = 0; m < 3; m++) w[m] = $urandom;
      loaded = 0; nb = 0; got = 0; acc = 0;
      for (int i = 0; i < 120; i++) begin
        cycle(loaded < 3, (loaded < 3) ? w[loaded] : 32'h0, e_list[j], 1'b1);
        if (o_valid) begin
          n_cmp++; if ((o_trace >> t) !== 8'h00) begin n_err++; $display("FAIL rt_upper_lanes e=%0d got=%h exp lanes>=%0d zero", e_list[j], o_trace, t); end
          for (int k = 0; k < t; k++) acc[nb*t + k] = o_trace[k];
          nb++;
          if (nb == n) begin
            e_w = (word_q.size() > 0) ? word_q.pop_front() : 32'hXXXX_XXXX;
            n_cmp++; if (acc !== e_w) begin n_err++; $display("FAIL rt_word e=%0d got=%h exp=%h", e_list[j], acc, e_w); end
            nb = 0; acc = 0; got++;
          end
        end
        if (o_load) begin word_q.push_back(w[loaded]); loaded++; end
      end
      n_cmp++; if (got != 3 || word_q.size() != 0) begin n_err++; $display("FAIL rt_count e=%0d got=%0d left=%0d exp 3/0", e_list[j], got, word_q.size()); end
      word_q.delete();
    end
  endtask

  initial begin
    bus.LOAD_PERM_I = 1'b0;
    bus.DATA_I = '0;
    bus.EXP_TRACES_I = '0;
    bus.TRACE_READY_I = 1'b0;
    test_reset();
    test_exp0();
    test_back_to_back();
    test_stall();
    test_no_perm();
    test_exp_change();
    test_reset_mid();
    test_round_trip();
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
